// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler for the 5-stage MIPS core.
// Tracks destination register and Tnew of the instructions in E/M/W and compares
// them with the D-stage source registers and their Tuse. It raises stall (hold PC
// and F/D, bubble into D/E) and produces forwarding selects for D- and E-stage operands.
// Optional HI/LO busy tracking is compiled in when HAZ_MD_EN is defined.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_use,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       stall,
    output logic [1:0] fwd_D_rs,
    output logic [1:0] fwd_D_rt,
    output logic [1:0] fwd_E_rs,
    output logic [1:0] fwd_E_rt,
    output logic       md_busy
);

    localparam logic [1:0] SEL_GRF = 2'd0;
    localparam logic [1:0] SEL_E   = 2'd1;
    localparam logic [1:0] SEL_M   = 2'd2;
    localparam logic [1:0] SEL_W   = 2'd3;

    logic [4:0] E_A3;
    logic [1:0] E_Tnew;
    logic [4:0] E_rs;
    logic [4:0] E_rt;
    logic [4:0] M_A3;
    logic [1:0] M_Tnew;
    logic [4:0] W_A3;

    logic       stall_rs;
    logic       stall_rt;
    logic       md_stall;

    // A source stalls when an in-flight producer of it is not ready by the time it is used.
    // Register 0 and "unused" (Tuse = 3) sources never stall.
    function automatic logic src_stall(
        input logic [4:0] s,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (e_a3 == s) && (e_tnew > tuse);
        hit_m = (m_a3 == s) && (m_tnew > tuse);
        return (s != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
    endfunction

    // Youngest producer wins; a younger match that is not ready yet blocks older ones.
    function automatic logic [1:0] d_fwd_sel(
        input logic [4:0] s,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = SEL_GRF;
        if (s != 5'd0) begin
            if (e_a3 == s) begin
                sel = (e_tnew == 2'd0) ? SEL_E : SEL_GRF;
            end else if (m_a3 == s) begin
                sel = (m_tnew == 2'd0) ? SEL_M : SEL_GRF;
            end else if (w_a3 == s) begin
                sel = SEL_W;
            end
        end
        return sel;
    endfunction

    function automatic logic [1:0] e_fwd_sel(
        input logic [4:0] s,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew,
        input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = SEL_GRF;
        if (s != 5'd0) begin
            if (m_a3 == s) begin
                sel = (m_tnew == 2'd0) ? SEL_M : SEL_GRF;
            end else if (w_a3 == s) begin
                sel = SEL_W;
            end
        end
        return sel;
    endfunction

    // Pipeline tracking: E takes the D fields or a bubble; M and W always advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            E_A3   <= 5'd0;
            E_Tnew <= 2'd0;
            E_rs   <= 5'd0;
            E_rt   <= 5'd0;
            M_A3   <= 5'd0;
            M_Tnew <= 2'd0;
            W_A3   <= 5'd0;
        end else begin
            if (stall) begin
                E_A3   <= 5'd0;
                E_Tnew <= 2'd0;
                E_rs   <= 5'd0;
                E_rt   <= 5'd0;
            end else begin
                E_A3   <= D_A3;
                E_Tnew <= D_Tnew;
                E_rs   <= D_rs_addr;
                E_rt   <= D_rt_addr;
            end
            M_A3   <= E_A3;
            M_Tnew <= (E_Tnew == 2'd0) ? 2'd0 : E_Tnew - 2'd1;
            W_A3   <= M_A3;
        end
    end

    // Stall and forwarding are purely combinational so they act in the same cycle.
    always_comb begin
        stall_rs = src_stall(D_rs_addr, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
        stall_rt = src_stall(D_rt_addr, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
        stall    = stall_rs | stall_rt | md_stall;
        fwd_D_rs = d_fwd_sel(D_rs_addr, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        fwd_D_rt = d_fwd_sel(D_rt_addr, E_A3, E_Tnew, M_A3, M_Tnew, W_A3);
        fwd_E_rs = e_fwd_sel(E_rs, M_A3, M_Tnew, W_A3);
        fwd_E_rt = e_fwd_sel(E_rt, M_A3, M_Tnew, W_A3);
    end

`ifdef HAZ_MD_EN
    logic [3:0] md_cnt;

    // HI/LO busy down-counter; a new start always reloads, even while busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (E_md_start) begin
            md_cnt <= E_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy  = E_md_start | (md_cnt != 4'd0);
    assign md_stall = D_md_use & md_busy;
`else
    // Without the HI/LO unit the md inputs and cycle counts have no effect.
    logic unused_md;
    assign unused_md = ^{D_md_use, E_md_start, E_md_is_div, 4'(MULT_CYCLES), 4'(DIV_CYCLES)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule
